// File: rtl/tcam_search_ctrl.sv
// tcam_search_ctrl: request/response front end for a registered-output tcam.
//   Buffers search requests (key + tag) in a FIFO. Issues at most one search per cycle on
//   tcam_search_en/tcam_search_key. Captures the tcam match one cycle after each issue into a
//   2-entry response buffer, which drains through rsp_valid/rsp_ready. Keeps saturating
//   hit/miss counters.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready/key/tag      request in (ready = FIFO not full, 0 in reset)
//   tcam_search_en/key               search issue to tcam
//   tcam_match_found/data            registered tcam result, valid one cycle after issue
//   rsp_valid/ready/tag/hit/data     tagged response out (data 0 on miss)
//   clr_stats, hit_count, miss_count statistics
//   busy                             any request queued, in flight or held
module tcam_search_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_key,
  input  logic [TAG_W-1:0] req_tag,
  output logic             tcam_search_en,
  output logic [WIDTH-1:0] tcam_search_key,
  input  logic             tcam_match_found,
  input  logic [WIDTH-1:0] tcam_match_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_hit,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic             busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  // Request FIFO; pointers carry an extra wrap bit to tell full from empty.
  logic [WIDTH-1:0] fifo_key_q [FIFO_DEPTH];
  logic [TAG_W-1:0] fifo_tag_q [FIFO_DEPTH];
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             fifo_empty, fifo_full, push, issue;

  // In-flight search and 2-entry response buffer.
  logic             inflight_q, inflight_d;
  logic [TAG_W-1:0] inflight_tag_q, inflight_tag_d;
  logic [TAG_W-1:0] rsp_tag_q  [2];
  logic             rsp_hit_q  [2];
  logic [WIDTH-1:0] rsp_data_q [2];
  logic [1:0]       rsp_cnt_q, rsp_cnt_d;
  logic             rsp_head_q, rsp_head_d;
  logic             rsp_tail, rsp_pop, capture;
  logic [1:0]       occupancy;

  logic [CNT_W-1:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign req_ready  = rst_n & ~fifo_full;
  assign push       = req_valid & req_ready;

  assign rsp_valid = (rsp_cnt_q != 2'd0);
  assign rsp_pop   = rsp_valid & rsp_ready;
  assign capture   = inflight_q;
  // Slot the next capture lands in; with 2 held a capture only happens alongside a pop,
  // so the freed head slot is reused.
  assign rsp_tail  = rsp_head_q ^ rsp_cnt_q[0];

  // Held responses (after this cycle's pop) plus the in-flight one must leave room.
  assign occupancy = rsp_cnt_q - 2'(rsp_pop) + 2'(inflight_q);
  assign issue     = !fifo_empty && (occupancy < 2'd2);

  assign tcam_search_en  = issue;
  assign tcam_search_key = issue ? fifo_key_q[rd_ptr_q[PtrW-1:0]] : '0;

  assign rsp_tag  = rsp_valid ? rsp_tag_q[rsp_head_q]  : '0;
  assign rsp_hit  = rsp_valid ? rsp_hit_q[rsp_head_q]  : 1'b0;
  assign rsp_data = rsp_valid ? rsp_data_q[rsp_head_q] : '0;

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign busy       = !fifo_empty || inflight_q || rsp_valid;

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    inflight_d     = issue;
    inflight_tag_d = inflight_tag_q;
    rsp_cnt_d      = rsp_cnt_q + 2'(capture) - 2'(rsp_pop);
    rsp_head_d     = rsp_head_q ^ rsp_pop;
    hit_count_d    = hit_count_q;
    miss_count_d   = miss_count_q;
    if (push) wr_ptr_d = wr_ptr_q + (PtrW + 1)'(1);
    if (issue) begin
      rd_ptr_d       = rd_ptr_q + (PtrW + 1)'(1);
      inflight_tag_d = fifo_tag_q[rd_ptr_q[PtrW-1:0]];
    end
    // Clear takes priority over a same-cycle capture.
    if (clr_stats) begin
      hit_count_d  = '0;
      miss_count_d = '0;
    end else if (capture) begin
      if (tcam_match_found) begin
        if (hit_count_q != {CNT_W{1'b1}}) hit_count_d = hit_count_q + CNT_W'(1);
      end else begin
        if (miss_count_q != {CNT_W{1'b1}}) miss_count_d = miss_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_key_q[wr_ptr_q[PtrW-1:0]] <= req_key;
      fifo_tag_q[wr_ptr_q[PtrW-1:0]] <= req_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= '0;
      rsp_cnt_q      <= '0;
      rsp_head_q     <= 1'b0;
      hit_count_q    <= '0;
      miss_count_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        rsp_tag_q[i]  <= '0;
        rsp_hit_q[i]  <= 1'b0;
        rsp_data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      inflight_q     <= inflight_d;
      inflight_tag_q <= inflight_tag_d;
      rsp_cnt_q      <= rsp_cnt_d;
      rsp_head_q     <= rsp_head_d;
      hit_count_q    <= hit_count_d;
      miss_count_q   <= miss_count_d;
      if (capture) begin
        rsp_tag_q[rsp_tail]  <= inflight_tag_q;
        rsp_hit_q[rsp_tail]  <= tcam_match_found;
        rsp_data_q[rsp_tail] <= tcam_match_found ? tcam_match_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_tcam_search_ctrl.sv
// Testbench for tcam_search_ctrl with a small behavioural tcam and a response scoreboard.
module tb_tcam_search_ctrl;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned CMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid, req_ready;
  logic [WIDTH-1:0] req_key;
  logic [TAG_W-1:0] req_tag;
  logic             tcam_search_en;
  logic [WIDTH-1:0] tcam_search_key;
  logic             tcam_match_found = 1'b0;
  logic [WIDTH-1:0] tcam_match_data = '0;
  logic             rsp_valid, rsp_ready, rsp_hit;
  logic [TAG_W-1:0] rsp_tag;
  logic [WIDTH-1:0] rsp_data;
  logic             clr_stats;
  logic [CNT_W-1:0] hit_count, miss_count;
  logic             busy;

  tcam_search_ctrl #(
    .WIDTH(WIDTH), .TAG_W(TAG_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_tag(req_tag),
    .tcam_search_en(tcam_search_en), .tcam_search_key(tcam_search_key),
    .tcam_match_found(tcam_match_found), .tcam_match_data(tcam_match_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_hit(rsp_hit),
    .rsp_data(rsp_data), .clr_stats(clr_stats), .hit_count(hit_count),
    .miss_count(miss_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic [WIDTH-1:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  int          n_vec = 0, n_err = 0;
  int unsigned cyc = 0;
  int unsigned exp_hit = 0, exp_miss = 0;
  int          issue_cnt = 0, rsp_seen = 0, stalls = 0;
  int unsigned last_en = 0, en_run = 0, en_max = 0;
  int unsigned last_rs = 0, rs_run = 0, rs_max = 0;
  int unsigned acc_cyc = 0;
  bit          rand_done = 0;

  // Behavioural tcam: lowest matching entry wins, result registered one cycle after search.
  logic [WIDTH-1:0] tc_data [4];
  logic [WIDTH-1:0] tc_mask [4];
  logic             tc_vld  [4];

  function automatic logic tc_hit(input logic [WIDTH-1:0] key);
    for (int i = 0; i < 4; i++)
      if (tc_vld[i] && (((key ^ tc_data[i]) & tc_mask[i]) == '0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [WIDTH-1:0] tc_dout(input logic [WIDTH-1:0] key);
    for (int i = 0; i < 4; i++)
      if (tc_vld[i] && (((key ^ tc_data[i]) & tc_mask[i]) == '0)) return tc_data[i];
    return '0;
  endfunction

  // Garbage on miss and in idle cycles so the DUT must ignore/zero it.
  always @(posedge clk) begin
    if (tcam_search_en) begin
      tcam_match_found <= tc_hit(tcam_search_key);
      tcam_match_data  <= tc_hit(tcam_search_key) ? tc_dout(tcam_search_key)
                                                  : WIDTH'($urandom);
    end else begin
      tcam_match_found <= 1'($urandom);
      tcam_match_data  <= WIDTH'($urandom);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard on every accepted response.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got tag %0d, expected no response", rsp_tag);
      end else begin
        e = exp_q.pop_front();
        check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
        check("rsp_hit", 32'(rsp_hit), 32'(e.hit));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  end

  // Run-length trackers for issue and response streams.
  always @(negedge clk) begin
    if (tcam_search_en) begin
      issue_cnt++;
      en_run = (cyc == last_en + 1) ? en_run + 1 : 1;
      last_en = cyc;
      if (en_run > en_max) en_max = en_run;
    end
    if (rsp_valid && rsp_ready) begin
      rsp_seen++;
      rs_run = (cyc == last_rs + 1) ? rs_run + 1 : 1;
      last_rs = cyc;
      if (rs_run > rs_max) rs_max = rs_run;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] key, input logic [TAG_W-1:0] tag);
    int   n = 0;
    rsp_t e;
    req_valid = 1'b1;
    req_key   = key;
    req_tag   = tag;
    @(negedge clk);
    if (!req_ready) stalls++;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL req_timeout: got req_ready=0 for 200 cycles, expected 1");
    end else begin
      e.tag  = tag;
      e.hit  = tc_hit(key);
      e.data = e.hit ? tc_dout(key) : '0;
      exp_q.push_back(e);
      acc_cyc = cyc;
      if (e.hit) exp_hit = (exp_hit == CMAX) ? CMAX : exp_hit + 1;
      else       exp_miss = (exp_miss == CMAX) ? CMAX : exp_miss + 1;
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", {30'd0, busy, exp_q.size() != 0}, 32'd0);
    tick();
  endtask

  function automatic logic [WIDTH-1:0] rand_key();
    case ($urandom % 4)
      0:       return 8'hA5;
      1:       return {4'h3, 4'($urandom)};
      2:       return {4'($urandom), 4'hC};
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    req_valid = 1'b0; req_key = '0; req_tag = '0; rsp_ready = 1'b1; clr_stats = 1'b0;
    tc_data[0] = 8'hA5; tc_mask[0] = 8'hFF; tc_vld[0] = 1'b1;
    tc_data[1] = 8'h30; tc_mask[1] = 8'hF0; tc_vld[1] = 1'b1;
    tc_data[2] = 8'h0C; tc_mask[2] = 8'h0F; tc_vld[2] = 1'b1;
    tc_data[3] = 8'h80; tc_mask[3] = 8'hFF; tc_vld[3] = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_search_en", 32'(tcam_search_en), 0);
    check("rst_counts", {hit_count, miss_count}, 0);
    rst_n = 1'b1;
    tick();
    check("req_ready_after_rst", 32'(req_ready), 1);

    // Single hit: issue at A+1, response at A+3
    send(8'hA5, 4'd3);
    @(negedge clk);
    check("lat_search_en", 32'(tcam_search_en), 1);
    check("lat_search_key", 32'(tcam_search_key), 32'hA5);
    @(negedge clk);
    check("lat_rsp_early", 32'(rsp_valid), 0);
    @(negedge clk);
    check("lat_rsp_valid", 32'(rsp_valid), 1);
    check("lat_rsp_cycle", cyc - acc_cyc, 3);
    wait_idle();
    check("hit_count_1", 32'(hit_count), exp_hit);

    // Miss: data zeroed, tag kept
    send(8'h11, 4'd9);
    wait_idle();
    check("miss_count_1", 32'(miss_count), exp_miss);

    // Eight back-to-back requests
    en_max = 0; rs_max = 0; stalls = 0;
    for (int i = 0; i < 8; i++) send(rand_key(), 4'(i));
    wait_idle();
    check("b2b_issue_run", en_max, 8);
    check("b2b_rsp_run", rs_max, 8);
    check("b2b_no_stall", stalls, 0);

    // Backpressure: two issued, FIFO fills, then drain
    begin
      int base_i, base_r;
      rsp_ready = 1'b0;
      base_i = issue_cnt;
      base_r = rsp_seen;
      for (int i = 0; i < 6; i++) send(rand_key(), 4'(i + 4));
      repeat (4) tick();
      @(negedge clk);
      check("bp_issued", issue_cnt - base_i, 2);
      check("bp_req_ready", 32'(req_ready), 0);
      check("bp_busy", 32'(busy), 1);
      tick();
      wait_idle();
      check("bp_rsp_total", rsp_seen - base_r, 6);
    end
    check("bp_hit_count", 32'(hit_count), exp_hit);
    check("bp_miss_count", 32'(miss_count), exp_miss);

    // Reset with one held, one in flight, one queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'hA5, 4'(i));
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_counts", {hit_count, miss_count}, 0);
    check("mid_rst_req_ready", 32'(req_ready), 0);
    exp_q.delete();
    exp_hit = 0;
    exp_miss = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rsp_ready = 1'b1;
    repeat (10) tick();
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_rsp_valid", 32'(rsp_valid), 0);

    // Saturation, then clear coinciding with a capture
    for (int i = 0; i < 5; i++) send(8'hA5, 4'(i));
    wait_idle();
    check("sat_hit_count", 32'(hit_count), exp_hit);
    send(8'hA5, 4'd7);
    tick();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    exp_hit = 0;
    exp_miss = 0;
    wait_idle();
    check("clr_vs_capture_hit", 32'(hit_count), 0);
    check("clr_vs_capture_miss", 32'(miss_count), 0);
    send(8'h11, 4'd2);
    wait_idle();
    check("after_clr_miss", 32'(miss_count), exp_miss);

    // Randomized traffic with random response backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom % 3) tick();
          send(rand_key(), 4'($urandom));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          rsp_ready = ($urandom % 4) != 0;
          tick();
        end
      end
    join
    wait_idle();
    check("rand_hit_count", 32'(hit_count), exp_hit);
    check("rand_miss_count", 32'(miss_count), exp_miss);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
